// File: rtl/mcu_core_param_if.sv
// Run/Done handshake plus internal bus of mcu_core_param.
// Optional Z/C flag signals exist only when MCU_FLAGS_EN is defined.
interface mcu_core_param_if #(
   parameter int unsigned DATA_W = 16
);
   logic              Run;
   logic [DATA_W-1:0] DIN;
   logic              Done;
   logic [DATA_W-1:0] Bus;
`ifdef MCU_FLAGS_EN
   logic              Z;
   logic              C;

   modport master (output Run, output DIN, input Done, input Bus, input Z, input C);
   modport slave  (input Run, input DIN, output Done, output Bus, output Z, output C);
`else
   modport master (output Run, output DIN, input Done, input Bus);
   modport slave  (input Run, input DIN, output Done, output Bus);
`endif
endinterface

// File: rtl/mcu_core_param.sv
// Parametrised multi-cycle MCU core: mv/mvi/add/sub/and/or sequenced over T0..T3.
// Define MCU_FLAGS_EN to add Z/C flags and the mvnz instruction (opcode 110).
module mcu_core_param #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned NUM_REGS = 8
) (
   input logic            Mclk,
   input logic            Reset,
   mcu_core_param_if.slave bus_if
);
   localparam int unsigned REG_AW = $clog2(NUM_REGS);
   localparam int unsigned IW     = 3 + 2 * REG_AW;

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
`ifdef MCU_FLAGS_EN
   localparam logic [2:0] OP_MVNZ = 3'b110;
`endif

   logic [1:0]        state_q, state_d;
   logic [IW-1:0]     ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] g_q, g_d;
   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic              rf_we;

   logic [DATA_W-1:0] bus_c;
   logic              done_c;

   logic [2:0]        opc;
   logic [REG_AW-1:0] rx, ry;
   logic [DATA_W-1:0] rx_val, ry_val;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;

`ifdef MCU_FLAGS_EN
   logic z_q, z_d;
   logic c_q, c_d;
`else
   logic unused_flag_bits;
   assign unused_flag_bits = alu_carry;
`endif

   assign opc    = ir_q[IW-1:IW-3];
   assign rx     = ir_q[2*REG_AW-1:REG_AW];
   assign ry     = ir_q[REG_AW-1:0];
   assign rx_val = rf_q[rx];
   assign ry_val = rf_q[ry];

   // ALU: A op Bus, where Bus carries Ry during T2
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (opc)
         OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, ry_val};
         OP_SUB: begin
            alu_res   = a_q + ~ry_val + DATA_W'(1);
            alu_carry = (a_q < ry_val);
         end
         OP_AND:  alu_res = a_q & ry_val;
         OP_OR:   alu_res = a_q | ry_val;
         default: alu_res = '0;
      endcase
   end

   // Timing controller: next state, bus source, Done and register enables
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      a_d     = a_q;
      g_d     = g_q;
      bus_c   = '0;
      done_c  = 1'b0;
      rf_we   = 1'b0;
`ifdef MCU_FLAGS_EN
      z_d     = z_q;
      c_d     = c_q;
`endif
      case (state_q)
         T0: begin
            if (bus_if.Run) begin
               ir_d    = bus_if.DIN[IW-1:0];
               state_d = T1;
            end
         end
         T1: begin
            case (opc)
               OP_MV: begin
                  bus_c   = ry_val;
                  rf_we   = 1'b1;
                  done_c  = 1'b1;
                  state_d = T0;
               end
               OP_MVI: begin
                  bus_c   = bus_if.DIN;
                  rf_we   = 1'b1;
                  done_c  = 1'b1;
                  state_d = T0;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  bus_c   = rx_val;
                  a_d     = rx_val;
                  state_d = T2;
               end
`ifdef MCU_FLAGS_EN
               OP_MVNZ: begin
                  if (!z_q) begin
                     bus_c = ry_val;
                     rf_we = 1'b1;
                  end
                  done_c  = 1'b1;
                  state_d = T0;
               end
`endif
               default: begin
                  done_c  = 1'b1;
                  state_d = T0;
               end
            endcase
         end
         T2: begin
            bus_c   = ry_val;
            g_d     = alu_res;
`ifdef MCU_FLAGS_EN
            z_d     = (alu_res == '0);
            c_d     = alu_carry;
`endif
            state_d = T3;
         end
         T3: begin
            bus_c   = g_q;
            rf_we   = 1'b1;
            done_c  = 1'b1;
            state_d = T0;
         end
         default: state_d = T0;
      endcase
   end

   always_ff @(posedge Mclk) begin
      if (Reset) begin
         state_q <= T0;
         ir_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
`ifdef MCU_FLAGS_EN
         z_q     <= 1'b0;
         c_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         g_q     <= g_d;
         if (rf_we) rf_q[rx] <= bus_c;
`ifdef MCU_FLAGS_EN
         z_q     <= z_d;
         c_q     <= c_d;
`endif
      end
   end

   assign bus_if.Done = done_c;
   assign bus_if.Bus  = bus_c;
`ifdef MCU_FLAGS_EN
   assign bus_if.Z    = z_q;
   assign bus_if.C    = c_q;
`endif

endmodule
